// File: rtl/vec_store_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_store_streamer
//  Description : Vector store-side reader. Reads one vector register through
//                a regfile read port, snapshots all VLEN elements, then streams
//                them one element per beat on a valid/ready memory-write
//                channel with strided byte addresses.
//                Optional feature macro: VSTORE_MASK_EN (adds per-element
//                vmask input; masked elements are skipped but still consume
//                one stream cycle and one stride step).
//  Revision    : 1.0  initial release
// ============================================================================
module vec_store_streamer #(
    parameter int ELEN = 32,
    parameter int VLEN = 64,
    parameter int AW   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            vsrc,
    input  logic [AW-1:0]         base,
    input  logic [AW-1:0]         stride,
    input  logic [$clog2(VLEN):0] vl,
    output logic [4:0]            vaddr,
    input  logic [ELEN-1:0]       vdat [0:VLEN-1],
`ifdef VSTORE_MASK_EN
    input  logic [VLEN-1:0]       vmask,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [AW-1:0]         m_addr,
    output logic [ELEN-1:0]       m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IW  = $clog2(VLEN);
    localparam int VLW = IW + 1;
    localparam logic [VLW-1:0] VLEN_C = VLW'(VLEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_STREAM  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        vaddr_q, vaddr_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW-1:0]     stride_q, stride_d;
    logic [VLW-1:0]    vl_q, vl_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [ELEN-1:0]   snap_q [0:VLEN-1];
    logic [ELEN-1:0]   snap_d [0:VLEN-1];

    // Capture-time summary: index of the final beat and whether any beat exists
    logic [IW-1:0]     w_last_idx;
    logic              w_empty;
    // Current element is sent (1) or skipped silently (0)
    logic              w_elem_active;
    logic              w_advance;

`ifdef VSTORE_MASK_EN
    logic [VLEN-1:0]   mask_q, mask_d;

    // Highest active element below vl determines the final beat
    always_comb begin
        w_empty    = 1'b1;
        w_last_idx = '0;
        for (int i = 0; i < VLEN; i++) begin
            if ((VLW'(i) < vl_q) && mask_q[i]) begin
                w_empty    = 1'b0;
                w_last_idx = IW'(i);
            end
        end
    end

    assign w_elem_active = mask_q[idx_q];
`else
    assign w_empty       = (vl_q == '0);
    assign w_last_idx    = IW'(vl_q - VLW'(1));
    assign w_elem_active = 1'b1;
`endif

    // Skipped elements advance without waiting for the sink
    assign w_advance = w_elem_active ? m_ready : 1'b1;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        vaddr_d  = vaddr_q;
        base_d   = base_q;
        stride_d = stride_q;
        vl_d     = vl_q;
        idx_d    = idx_q;
        last_d   = last_q;
        acc_d    = acc_q;
        snap_d   = snap_q;
`ifdef VSTORE_MASK_EN
        mask_d   = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vaddr_d  = vsrc;
                    base_d   = base;
                    stride_d = stride;
                    vl_d     = (vl > VLEN_C) ? VLEN_C : vl;
`ifdef VSTORE_MASK_EN
                    mask_d   = vmask;
`endif
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // vaddr has been stable for a full cycle: vdat is the register
                snap_d  = vdat;
                idx_d   = '0;
                acc_d   = base_q;
                last_d  = w_last_idx;
                state_d = w_empty ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (w_advance) begin
                    idx_d = idx_q + IW'(1);
                    acc_d = acc_q + stride_q;
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            vaddr_q  <= '0;
            base_q   <= '0;
            stride_q <= '0;
            vl_q     <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            snap_q   <= '{default: '0};
`ifdef VSTORE_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vaddr_q  <= vaddr_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            vl_q     <= vl_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            snap_q   <= snap_d;
`ifdef VSTORE_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end

    // Outputs decode registered state only; nothing depends on m_ready
    always_comb begin
        vaddr   = vaddr_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        m_valid = (state_q == S_STREAM) && w_elem_active;
        m_addr  = (state_q == S_STREAM) ? acc_q : '0;
        m_data  = (state_q == S_STREAM) ? snap_q[idx_q] : '0;
        m_last  = m_valid && (idx_q == last_q);
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_store_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vec_store_streamer
//  Description : Scoreboard bench for vec_store_streamer. Stimulus pushes the
//                expected beats; a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vec_store_streamer;

    localparam int ELEN = 32;
    localparam int VLEN = 64;
    localparam int AW   = 32;
    localparam int VLW  = $clog2(VLEN) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [4:0]        vsrc;
    logic [AW-1:0]     base;
    logic [AW-1:0]     stride;
    logic [VLW-1:0]    vl;
    logic [4:0]        vaddr;
    logic [ELEN-1:0]   vdat [0:VLEN-1];
    logic              m_valid;
    logic              m_ready;
    logic [AW-1:0]     m_addr;
    logic [ELEN-1:0]   m_data;
    logic              m_last;
    logic              busy;
    logic              done;
`ifdef VSTORE_MASK_EN
    logic [VLEN-1:0]   vmask;
`endif

    logic [ELEN-1:0]   rf [0:31][0:VLEN-1];

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [ELEN-1:0] data;
        logic            last;
    } beat_t;

    beat_t sb[$];
    int    checks     = 0;
    int    errors     = 0;
    int    cyc        = 0;
    int    ready_mode = 0;
    int    rcnt       = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Regfile read port model: combinational read at vaddr
    always_comb begin
        for (int i = 0; i < VLEN; i++) vdat[i] = rf[vaddr][i];
    end

    vec_store_streamer #(.ELEN(ELEN), .VLEN(VLEN), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vsrc    (vsrc),
        .base    (base),
        .stride  (stride),
        .vl      (vl),
        .vaddr   (vaddr),
        .vdat    (vdat),
`ifdef VSTORE_MASK_EN
        .vmask   (vmask),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink ready: always high, or the repeating pattern 1,0,0
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                m_ready = (rcnt % 3 == 0);
                rcnt++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: pop and compare on every handshake; check hold while stalled
    beat_t mon_exp;
    beat_t mon_prev;
    logic  mon_stall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mon_stall) begin
                    chk("hold_valid", 64'(m_valid), 64'(1));
                    chk("hold_addr",  64'(m_addr),  64'(mon_prev.addr));
                    chk("hold_data",  64'(m_data),  64'(mon_prev.data));
                    chk("hold_last",  64'(m_last),  64'(mon_prev.last));
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got addr %0h data %0h, expected no beat",
                                 m_addr, m_data);
                    end else begin
                        mon_exp = sb.pop_front();
                        chk("beat_addr", 64'(m_addr), 64'(mon_exp.addr));
                        chk("beat_data", 64'(m_data), 64'(mon_exp.data));
                        chk("beat_last", 64'(m_last), 64'(mon_exp.last));
                    end
                end
                mon_stall     = m_valid && !m_ready;
                mon_prev.addr = m_addr;
                mon_prev.data = m_data;
                mon_prev.last = m_last;
            end else begin
                mon_stall = 1'b0;
            end
        end
    end

    // Push up to max_beats expected beats; returns the final active index (-1 if none)
    task automatic push_exp(input logic [4:0] r, input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input int n_in, input logic [VLEN-1:0] mk, input int max_beats,
                            output int last_idx);
        int    n;
        int    cnt;
        beat_t e;
        n        = (n_in > VLEN) ? VLEN : n_in;
        cnt      = 0;
        last_idx = -1;
        for (int i = 0; i < n; i++) if (mk[i]) last_idx = i;
        for (int i = 0; i < n; i++) begin
            if (mk[i] && cnt < max_beats) begin
                e.addr = b + AW'(i) * s;
                e.data = rf[r][i];
                e.last = (i == last_idx);
                sb.push_back(e);
                cnt++;
            end
        end
    endtask

    // One complete store; entered and left at posedge+1
    task automatic do_store(input logic [4:0] r, input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input int n, input logic [VLEN-1:0] mk, input int rmode,
                            input bit clobber, input bit poke_start);
        int last_idx;
        int t;
        int w;
        int exp_done;
        ready_mode = rmode;
        rcnt       = 0;
        push_exp(r, b, s, n, mk, VLEN, last_idx);
        exp_done = (last_idx < 0) ? 2 : last_idx + 3;
        vsrc   = r;
        base   = b;
        stride = s;
        vl     = VLW'(n);
`ifdef VSTORE_MASK_EN
        vmask  = mk;
`endif
        start  = 1'b1;
        t      = cyc;
        chk("idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        start  = 1'b0;
        vsrc   = 5'd0;
        base   = '0;
        stride = '0;
        vl     = '0;
        chk("cap_busy",  64'(busy),  64'(1));
        chk("cap_vaddr", 64'(vaddr), 64'(r));
        @(posedge clk);
        #1;
        if (clobber) begin
            for (int i = 0; i < VLEN; i++) rf[r][i] = ~rf[r][i];
        end
        if (poke_start) begin
            start = 1'b1;
            vsrc  = r ^ 5'd1;
            base  = 32'hDEAD_0000;
            vl    = VLW'(2);
        end
        w = 0;
        while (!done && w < 400) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            w++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 400 cycles, expected done");
        end else begin
            if (rmode == 0) chk("done_cycle", 64'(cyc - t), 64'(exp_done));
            chk("done_busy",  64'(busy),    64'(1));
            chk("done_valid", 64'(m_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        chk("idle_after_done", 64'({busy, done}), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    logic [VLEN-1:0] ones;
    int              li;

    initial begin
        ones   = '1;
        rst    = 1'b0;
        start  = 1'b0;
        vsrc   = '0;
        base   = '0;
        stride = '0;
        vl     = '0;
`ifdef VSTORE_MASK_EN
        vmask  = '0;
`endif
        for (int r = 0; r < 32; r++)
            for (int i = 0; i < VLEN; i++) rf[r][i] = 32'h5A5A_0000 + (r << 8) + i;
        for (int i = 0; i < VLEN; i++) begin
            rf[3][i] = 32'h100 + i;
            rf[5][i] = 32'hA500_0000 + i;
            rf[7][i] = (i * 32'h0101_0101) ^ 32'hDEAD_0000;
            rf[9][i] = 32'hC0DE_0000 | i;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_busy",  64'(busy),    64'(0));
        chk("rst_done",  64'(done),    64'(0));
        chk("rst_vaddr", 64'(vaddr),   64'(0));
        chk("rst_addr",  64'(m_addr),  64'(0));
        chk("rst_data",  64'(m_data),  64'(0));
        chk("rst_last",  64'(m_last),  64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic store: beats (0x1000,0x100)..(0x100C,0x103)
        do_store(5'd3, 32'h1000, 32'd4, 4, ones, 0, 1'b0, 1'b0);
        // Same store under 1,0,0 backpressure with a stray start mid-stream
        do_store(5'd3, 32'h1000, 32'd4, 4, ones, 1, 1'b0, 1'b1);
        // Empty store
        do_store(5'd3, 32'h1000, 32'd4, 0, ones, 0, 1'b0, 1'b0);
        // Over-length vl clamps to VLEN; regfile overwritten after capture
        do_store(5'd7, 32'h4000, 32'h10, VLEN + 5, ones, 0, 1'b1, 1'b0);
        // Address wrap
        do_store(5'd9, 32'hFFFF_FFF8, 32'd8, 3, ones, 0, 1'b0, 1'b0);

        // Reset after the 2nd beat of a vl=8 store
        ready_mode = 0;
        push_exp(5'd5, 32'h2000, 32'd4, 8, ones, 2, li);
        vsrc   = 5'd5;
        base   = 32'h2000;
        stride = 32'd4;
        vl     = VLW'(8);
`ifdef VSTORE_MASK_EN
        vmask  = ones;
`endif
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_busy",  64'(busy),    64'(0));
        chk("mid_rst_done",  64'(done),    64'(0));
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_done",  64'(done),    64'(0));
            chk("post_rst_valid", 64'(m_valid), 64'(0));
        end
        chk("rst_sb_empty", 64'(sb.size()), 64'(0));
        sb.delete();
        // Fresh start streams from element 0
        do_store(5'd5, 32'h2000, 32'd4, 8, ones, 0, 1'b0, 1'b0);

`ifdef VSTORE_MASK_EN
        // Mask 0b0101: elements 0 and 2 only, last on element 2
        do_store(5'd3, 32'h1000, 32'd4, 4, 64'b0101, 0, 1'b0, 1'b0);
        // No active element: no beats
        do_store(5'd3, 32'h1000, 32'd4, 4, 64'b0, 0, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
